// File: rtl/penyiraman_pkg.sv
// Shared definitions for the multi-zone irrigation controller:
// FSM state encoding, default geometry and a modular index helper.
package penyiraman_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WATER  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    localparam int DEFAULT_N_ZONE  = 4;
    localparam int DEFAULT_TIMER_W = 8;

    // (base + step) mod n, for base < n and step < n
    function automatic int wrap_add(input int base, input int step, input int n);
        int s;
        s = base + step;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requests starting at the pointer position and
// returns the first requester as a one-hot grant plus its index.
module rr_arbiter
    import penyiraman_pkg::*;
#(
    parameter int N = DEFAULT_N_ZONE
) (
    input  logic [N-1:0]         request,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] index,
    output logic                 valid
);

    localparam int IDX_W = $clog2(N);

    // Priority scan from pointer, wrapping around at N.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant    = '0;
        index    = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = wrap_add(int'(pointer), k, N);
            cand_idx = IDX_W'(cand);
            if (!valid && request[cand_idx]) begin
                valid           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/penyiraman_multi_zona.sv
// Multi-zone irrigation sequencer with one shared pump. Requests are latched
// into a pending register and served one zone at a time in round-robin order.
// Optional build macro: SOIL_ABORT_EN -- a wet-soil reading aborts the running
// zone and discards a request whose soil is already wet at grant.
//
// state  | meaning
// IDLE   | no zone active; sensors powered; arbitrate pending requests
// WATER  | valve of active zone open, pump running, timer counting down
// SETTLE | one cycle with pump and valve off; zone_done pulses
module penyiraman_multi_zona
    import penyiraman_pkg::*;
#(
    parameter int N_ZONE  = DEFAULT_N_ZONE,
    parameter int TIMER_W = DEFAULT_TIMER_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_ZONE-1:0]         start_req,
    input  logic [N_ZONE*TIMER_W-1:0] duration,
    input  logic [N_ZONE-1:0]         soil_wet,
    output logic                      pump_on,
    output logic [N_ZONE-1:0]         valve_on,
    output logic                      sensor_enable,
    output logic                      watering_in_progress,
    output logic [$clog2(N_ZONE)-1:0] active_zone,
    output logic [TIMER_W-1:0]        watering_timer,
    output logic [N_ZONE-1:0]         zone_done
);

    localparam int IDX_W = $clog2(N_ZONE);

    state_t              state;
    logic [N_ZONE-1:0]   pending;
    logic [N_ZONE-1:0]   pend_clr;
    logic [IDX_W-1:0]    rr_ptr;
    logic [N_ZONE-1:0]   grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [TIMER_W-1:0]  grant_dur;
    logic                grant_skip;
    logic                water_abort;
    logic                timer_last;

    rr_arbiter #(
        .N (N_ZONE)
    ) u_arb (
        .request (pending),
        .pointer (rr_ptr),
        .grant   (grant_oh),
        .index   (grant_idx),
        .valid   (grant_valid)
    );

    assign grant_dur  = duration[grant_idx*TIMER_W +: TIMER_W];
    assign timer_last = (watering_timer == TIMER_W'(1)) || (watering_timer == '0);

`ifdef SOIL_ABORT_EN
    assign grant_skip  = (grant_dur == '0) || soil_wet[grant_idx];
    assign water_abort = soil_wet[active_zone];
`else
    logic soil_wet_unused;
    assign soil_wet_unused = ^soil_wet;
    assign grant_skip      = (grant_dur == '0);
    assign water_abort     = 1'b0;
`endif

    // A grant (served or discarded) consumes that zone's pending bit.
    assign pend_clr = ((state == IDLE) && grant_valid) ? grant_oh : '0;

    // Pending requests: any start_req sets its bit, even while that zone waters.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~pend_clr) | start_req;
        end
    end

    // Sequencer FSM with registered drive outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            pump_on              <= 1'b0;
            valve_on             <= '0;
            sensor_enable        <= 1'b1;
            watering_in_progress <= 1'b0;
            active_zone          <= '0;
            watering_timer       <= '0;
            zone_done            <= '0;
        end else begin
            zone_done <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        rr_ptr <= IDX_W'(wrap_add(int'(grant_idx), 1, N_ZONE));
                        if (grant_skip) begin
                            // nothing to water: report completion without touching the pump
                            zone_done <= grant_oh;
                        end else begin
                            state                <= WATER;
                            valve_on             <= grant_oh;
                            pump_on              <= 1'b1;
                            sensor_enable        <= 1'b0;
                            watering_in_progress <= 1'b1;
                            active_zone          <= grant_idx;
                            watering_timer       <= grant_dur;
                        end
                    end
                end
                WATER: begin
                    if (watering_timer != '0) begin
                        watering_timer <= watering_timer - 1'b1;
                    end
                    if (timer_last || water_abort) begin
                        state          <= SETTLE;
                        pump_on        <= 1'b0;
                        valve_on       <= '0;
                        zone_done      <= valve_on;
                        watering_timer <= '0;
                    end
                end
                SETTLE: begin
                    state                <= IDLE;
                    sensor_enable        <= 1'b1;
                    watering_in_progress <= 1'b0;
                    active_zone          <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_penyiraman_multi_zona.sv
// Directed bench for penyiraman_multi_zona (N_ZONE=4, TIMER_W=8).
// Expectations for the wet-soil scenario follow the SOIL_ABORT_EN macro.
module tb_penyiraman_multi_zona;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  start_req;
    logic [31:0] duration;
    logic [3:0]  soil_wet;
    logic        pump_on;
    logic [3:0]  valve_on;
    logic        sensor_enable;
    logic        watering_in_progress;
    logic [1:0]  active_zone;
    logic [7:0]  watering_timer;
    logic [3:0]  zone_done;

    int total = 0;
    int bad   = 0;
    int busy  = 0;

    penyiraman_multi_zona #(
        .N_ZONE  (4),
        .TIMER_W (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start_req            (start_req),
        .duration             (duration),
        .soil_wet             (soil_wet),
        .pump_on              (pump_on),
        .valve_on             (valve_on),
        .sensor_enable        (sensor_enable),
        .watering_in_progress (watering_in_progress),
        .active_zone          (active_zone),
        .watering_timer       (watering_timer),
        .zone_done            (zone_done)
    );

    always #5 clk = ~clk;

    // one clock; outputs sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (watering_in_progress) busy++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Follows one zone from grant to idle; inject is pulsed on start_req in
    // the first WATER cycle, and duration is scrambled for the whole WATER phase.
    task automatic expect_zone(input int z, input int d, input logic [3:0] inject);
        int          n;
        logic [31:0] dsave;
        n = 0;
        while (!pump_on && n < 40) begin
            tick();
            n++;
        end
        check("grant_pump", 32'(pump_on), 1);
        check("grant_valve", 32'(valve_on), 32'(1 << z));
        check("grant_zone", 32'(active_zone), 32'(z));
        check("grant_sensor", 32'(sensor_enable), 0);
        n = 0;
        dsave = duration;
        while (pump_on && n < 300) begin
            check("timer", 32'(watering_timer), 32'(d - n));
            check("valve_hold", 32'(valve_on), 32'(1 << z));
            if (n == 0) begin
                start_req = inject;
                duration  = ~dsave;
            end
            tick();
            start_req = '0;
            n++;
        end
        duration = dsave;
        check("water_len", 32'(n), 32'(d));
        check("settle_done", 32'(zone_done), 32'(1 << z));
        check("settle_valve", 32'(valve_on), 0);
        check("settle_sensor", 32'(sensor_enable), 0);
        check("settle_wip", 32'(watering_in_progress), 1);
        tick();
        check("idle_sensor", 32'(sensor_enable), 1);
        check("idle_done", 32'(zone_done), 0);
        check("idle_wip", 32'(watering_in_progress), 0);
    endtask

    initial begin
        int n;
        int exp_len;
        reset     = 1'b1;
        start_req = '0;
        duration  = {8'd6, 8'd5, 8'd4, 8'd3};
        soil_wet  = '0;
        tick();
        tick();
        check("rst_pump", 32'(pump_on), 0);
        check("rst_valve", 32'(valve_on), 0);
        check("rst_sensor", 32'(sensor_enable), 1);
        check("rst_wip", 32'(watering_in_progress), 0);
        check("rst_zone", 32'(active_zone), 0);
        check("rst_timer", 32'(watering_timer), 0);
        check("rst_done", 32'(zone_done), 0);

        // single zone 2, duration 5
        reset     = 1'b0;
        start_req = 4'b0100;
        tick();
        start_req = '0;
        check("t1_idle_pump", 32'(pump_on), 0);
        expect_zone(2, 5, 4'b0000);

        // all four zones at once after reset: order 0..3, 22 busy cycles
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        start_req = 4'b1111;
        busy      = 0;
        tick();
        start_req = '0;
        expect_zone(0, 3, 4'b0000);
        expect_zone(1, 4, 4'b0000);
        expect_zone(2, 5, 4'b0000);
        expect_zone(3, 6, 4'b0000);
        check("t2_busy_cycles", 32'(busy), 22);

        // zero-duration zone 1 is discarded
        duration  = {8'd6, 8'd5, 8'd0, 8'd3};
        start_req = 4'b0010;
        tick();
        start_req = '0;
        tick();
        check("t3_done", 32'(zone_done), 32'h2);
        check("t3_pump", 32'(pump_on), 0);
        check("t3_valve", 32'(valve_on), 0);
        check("t3_sensor", 32'(sensor_enable), 1);
        tick();
        check("t3_done_clr", 32'(zone_done), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_quiet_pump", 32'({pump_on, valve_on}), 0);
        end

        // wet soil during zone 0 watering
        duration  = {8'd6, 8'd5, 8'd4, 8'd10};
        start_req = 4'b0001;
        tick();
        start_req = '0;
        n = 0;
        while (!pump_on && n < 10) begin
            tick();
            n++;
        end
        check("t4_grant", 32'(valve_on), 32'h1);
        n = 0;
        while (pump_on && n < 40) begin
            n++;
            if (n == 3) soil_wet = 4'b0001;
            tick();
        end
        soil_wet = '0;
`ifdef SOIL_ABORT_EN
        exp_len = 3;
`else
        exp_len = 10;
`endif
        check("t4_water_len", 32'(n), 32'(exp_len));
        check("t4_done", 32'(zone_done), 32'h1);
        tick();
        check("t4_idle_sensor", 32'(sensor_enable), 1);

        // reset during WATER closes everything without zone_done
        duration  = {8'd6, 8'd5, 8'd4, 8'd8};
        start_req = 4'b0001;
        tick();
        start_req = '0;
        n = 0;
        while (!pump_on && n < 10) begin
            tick();
            n++;
        end
        check("t5_pump_on", 32'(pump_on), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_pump", 32'(pump_on), 0);
        check("t5_valve", 32'(valve_on), 0);
        check("t5_sensor", 32'(sensor_enable), 1);
        check("t5_done", 32'(zone_done), 0);
        check("t5_timer", 32'(watering_timer), 0);
        check("t5_wip", 32'(watering_in_progress), 0);

        // zone 3 re-requests during its own watering while zone 1 pends
        duration  = {8'd4, 8'd2, 8'd7, 8'd2};
        start_req = 4'b1000;
        tick();
        start_req = '0;
        expect_zone(3, 4, 4'b1010);
        expect_zone(1, 7, 4'b0000);
        expect_zone(3, 4, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_quiet", 32'({pump_on, valve_on}), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/penyiraman_multi_zona.md
PENYIRAMAN_MULTI_ZONA -- requirements
Module: penyiraman_multi_zona

Interface
REQ-001 SHALL have parameter N_ZONE, default 4, number of irrigation zones (2..16).
REQ-002 SHALL have parameter TIMER_W, default 8, width of per-zone watering duration in clk cycles.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_req  input  N_ZONE  per-zone watering request, level, sampled every cycle.
REQ-006 duration  input  N_ZONE*TIMER_W  per-zone duration; zone i uses bits [i*TIMER_W +: TIMER_W].
REQ-007 soil_wet  input  N_ZONE  per-zone moisture sensor, 1 = soil wet.
REQ-008 pump_on  output  1  shared pump drive.
REQ-009 valve_on  output  N_ZONE  one-hot zone valve drive, all zero when idle.
REQ-010 sensor_enable  output  1  moisture sensors powered; 1 only when no zone waters.
REQ-011 watering_in_progress  output  1  high during WATER and SETTLE.
REQ-012 active_zone  output  $clog2(N_ZONE)  index of zone being served; 0 when idle.
REQ-013 watering_timer  output  TIMER_W  remaining cycles of current zone.
REQ-014 zone_done  output  N_ZONE  one-cycle pulse on the bit of the zone that finished or aborted.

Function
REQ-015 Pending register: bit i set when start_req[i]=1 in any cycle; cleared when zone i is granted.
REQ-016 Requests with duration[i]=0 SHALL be discarded at grant: no valve, no pump, zone_done[i] pulses once.
REQ-017 FSM states IDLE, WATER, SETTLE; only one zone waters at a time (single pump).
REQ-018 IDLE: if pending nonzero, grant by round-robin starting at (last granted + 1) mod N_ZONE; next cycle WATER, valve_on one-hot, pump_on=1, sensor_enable=0, watering_timer=duration of granted zone.
REQ-019 WATER: watering_timer decrements by 1 per cycle; when it reaches 1 and decrements to 0, next state SETTLE; zone waters exactly duration cycles.
REQ-020 SETTLE: exactly one cycle, pump_on=0, valve_on=0, zone_done pulse, sensor_enable stays 0; then IDLE with sensor_enable=1.
REQ-021 Duration sampled only at grant; changes during WATER SHALL NOT affect the running timer.
REQ-022 start_req for the active zone during WATER SHALL re-set its pending bit (served again after others).
REQ-023 Simultaneous requests from all zones after reset SHALL be served 0,1,...,N_ZONE-1.
REQ-024 No arithmetic wrap: watering_timer never decrements below 0.

Reset
REQ-025 On reset: state IDLE, pending=0, round-robin pointer set so zone 0 wins first, pump_on=0, valve_on=0, sensor_enable=1, watering_in_progress=0, active_zone=0, watering_timer=0, zone_done=0.
REQ-026 Reset asserted mid-WATER SHALL close valve and stop pump on the next clk edge; no zone_done pulse.

Configuration
REQ-027 Macro SOIL_ABORT_EN: when defined, soil_wet[active_zone]=1 sampled in WATER forces SETTLE next cycle (early stop, zone_done pulses); soil_wet high at grant discards the request like REQ-016.
REQ-028 Without SOIL_ABORT_EN, soil_wet SHALL be ignored and watering always runs full duration.

Structure
REQ-029 Shared package penyiraman_pkg SHALL hold state encoding (IDLE, WATER, SETTLE) and default N_ZONE/TIMER_W constants.
REQ-030 Round-robin arbiter SHALL be sub-module rr_arbiter (request, pointer -> one-hot grant, index, valid).

Verification
REQ-031 Reset, start_req[2]=1 pulse, duration[2]=5 -> valve_on=4'b0100, pump_on=1 for exactly 5 cycles, SETTLE 1 cycle, zone_done[2] pulse, sensor_enable back to 1.
REQ-032 All four start_req pulse same cycle, durations 3,4,5,6 -> zones served 0,1,2,3, each with 1-cycle SETTLE gap; total 22 cycles to idle.
REQ-033 duration[1]=0, start_req[1] pulse -> no pump or valve activity, zone_done[1] one pulse.
REQ-034 With SOIL_ABORT_EN, zone 0 duration 10, soil_wet[0] rises at cycle 3 of WATER -> SETTLE next cycle, zone_done[0] pulse; without macro -> full 10 cycles.
REQ-035 Reset asserted at cycle 2 of a duration-8 watering -> next edge pump_on=0, valve_on=0, sensor_enable=1, no zone_done.
REQ-036 Zone 3 re-requests during its own WATER while zone 1 pending -> order 3, 1, 3.
